// File: rtl/m_tlb_assoc_pkg.sv
// Shared constants for the set-associative TLB: flush modes, PTE flag layout,
// Sv32 VPN split point and the flush sweep FSM encoding.
package m_tlb_assoc_pkg;
  localparam int SV32_SPLIT = 10;

  localparam logic [1:0] TLBF_ALL     = 2'd0;
  localparam logic [1:0] TLBF_ASID    = 2'd1;
  localparam logic [1:0] TLBF_VPN     = 2'd2;
  localparam logic [1:0] TLBF_VPNASID = 2'd3;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;
  localparam logic [7:0] PTE_A_MASK = 8'h40;
  localparam logic [7:0] PTE_D_MASK = 8'h80;

  typedef enum logic [1:0] {TLB_IDLE, TLB_SWEEP, TLB_DONE} tlb_state_e;
endpackage

// File: rtl/m_tlb_assoc_way_match.sv
// Per-way comparator: lookup/refill match against one stored entry plus the
// SFENCE.VMA filter match used by the flush sweep.
module m_tlb_way_match
  import m_tlb_assoc_pkg::*;
#(
  parameter int VPN_W  = 20,
  parameter int ASID_W = 9
) (
  input  logic              valid,
  input  logic              is_super,
  input  logic              glob,
  input  logic [VPN_W-1:0]  tag_vpn,
  input  logic [ASID_W-1:0] tag_asid,
  input  logic [VPN_W-1:0]  vpn,
  input  logic [ASID_W-1:0] asid,
  input  logic              want_super,
  input  logic [1:0]        mode,
  output logic              lk_match,
  output logic              fl_match
);
  logic vpn_eq;
  logic asid_eq;

  // Superpages only carry the upper VPN bits as a tag.
  assign vpn_eq   = is_super ? (vpn[VPN_W-1:SV32_SPLIT] == tag_vpn[VPN_W-1:SV32_SPLIT])
                             : (vpn == tag_vpn);
  assign asid_eq  = (asid == tag_asid);
  assign lk_match = valid && (is_super == want_super) && (glob || asid_eq) && vpn_eq;

  always_comb begin
    case (mode)
      TLBF_ASID:    fl_match = valid && asid_eq && !glob;
      TLBF_VPN:     fl_match = valid && vpn_eq;
      TLBF_VPNASID: fl_match = valid && vpn_eq && asid_eq && !glob;
      default:      fl_match = valid;
    endcase
  end
endmodule

// File: rtl/m_tlb_assoc.sv
// Set-associative TLB with ASID/global/superpage support, combinational lookup,
// round-robin refill, selective flush sweep and saturating hit/miss counters.
module m_tlb_assoc
  import m_tlb_assoc_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int VPN_W  = 20,
  parameter int PPN_W  = 22,
  parameter int ASID_W = 9,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              w_lk_req,
  input  logic [VPN_W-1:0]  w_lk_vpn,
  input  logic [ASID_W-1:0] w_lk_asid,
  output logic              w_lk_hit,
  output logic [PPN_W-1:0]  w_lk_ppn,
  output logic [7:0]        w_lk_flags,
  input  logic              w_we,
  input  logic [VPN_W-1:0]  w_wvpn,
  input  logic [ASID_W-1:0] w_wasid,
  input  logic [PPN_W-1:0]  w_wppn,
  input  logic [7:0]        w_wflags,
  input  logic              w_wsuper,
  input  logic              w_flush_req,
  input  logic [1:0]        w_flush_mode,
  input  logic [VPN_W-1:0]  w_flush_vpn,
  input  logic [ASID_W-1:0] w_flush_asid,
  output logic              w_flush_busy,
  output logic              w_flush_done,
  output logic [CNT_W-1:0]  w_hit_cnt,
  output logic [CNT_W-1:0]  w_miss_cnt
);
  localparam int SW = $clog2(SETS);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   super_q [SETS];
  logic [WW-1:0]     rr_q    [SETS];
  logic [VPN_W-1:0]  vpn_q   [SETS][WAYS];
  logic [ASID_W-1:0] asid_q  [SETS][WAYS];
  logic [PPN_W-1:0]  ppn_q   [SETS][WAYS];
  logic [7:0]        flags_q [SETS][WAYS];

  tlb_state_e        state_q, state_d;
  logic [SW-1:0]     cnt_q;
  logic [1:0]        fl_mode_q;
  logic [VPN_W-1:0]  fl_vpn_q;
  logic [ASID_W-1:0] fl_asid_q;

  logic [SW-1:0]   lk_idx4, lk_idxs, rf_idx;
  logic [WAYS-1:0] lk4_m, lks_m, rf_m, sw_m;
  logic [WAYS-1:0] unused_fl4, unused_fls, unused_flrf, unused_lksw;
  logic            fl_start, fl_all, rf_en, use_rr, found;
  logic [WW-1:0]   victim;

  assign lk_idx4  = w_lk_vpn[SW-1:0];
  assign lk_idxs  = w_lk_vpn[SV32_SPLIT +: SW];
  assign rf_idx   = w_wsuper ? w_wvpn[SV32_SPLIT +: SW] : w_wvpn[SW-1:0];
  assign fl_start = (state_q == TLB_IDLE) && w_flush_req;
  assign fl_all   = fl_start && (w_flush_mode == TLBF_ALL);
  assign rf_en    = w_we && (((state_q == TLB_IDLE) && !w_flush_req) || (state_q == TLB_DONE));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    m_tlb_way_match #(.VPN_W(VPN_W), .ASID_W(ASID_W)) u_lk4 (
      .valid(valid_q[lk_idx4][w]), .is_super(super_q[lk_idx4][w]), .glob(flags_q[lk_idx4][w][PTE_G]),
      .tag_vpn(vpn_q[lk_idx4][w]), .tag_asid(asid_q[lk_idx4][w]), .vpn(w_lk_vpn), .asid(w_lk_asid),
      .want_super(1'b0), .mode(TLBF_ALL), .lk_match(lk4_m[w]), .fl_match(unused_fl4[w]));
    m_tlb_way_match #(.VPN_W(VPN_W), .ASID_W(ASID_W)) u_lks (
      .valid(valid_q[lk_idxs][w]), .is_super(super_q[lk_idxs][w]), .glob(flags_q[lk_idxs][w][PTE_G]),
      .tag_vpn(vpn_q[lk_idxs][w]), .tag_asid(asid_q[lk_idxs][w]), .vpn(w_lk_vpn), .asid(w_lk_asid),
      .want_super(1'b1), .mode(TLBF_ALL), .lk_match(lks_m[w]), .fl_match(unused_fls[w]));
    m_tlb_way_match #(.VPN_W(VPN_W), .ASID_W(ASID_W)) u_rf (
      .valid(valid_q[rf_idx][w]), .is_super(super_q[rf_idx][w]), .glob(flags_q[rf_idx][w][PTE_G]),
      .tag_vpn(vpn_q[rf_idx][w]), .tag_asid(asid_q[rf_idx][w]), .vpn(w_wvpn), .asid(w_wasid),
      .want_super(w_wsuper), .mode(TLBF_ALL), .lk_match(rf_m[w]), .fl_match(unused_flrf[w]));
    m_tlb_way_match #(.VPN_W(VPN_W), .ASID_W(ASID_W)) u_sw (
      .valid(valid_q[cnt_q][w]), .is_super(super_q[cnt_q][w]), .glob(flags_q[cnt_q][w][PTE_G]),
      .tag_vpn(vpn_q[cnt_q][w]), .tag_asid(asid_q[cnt_q][w]), .vpn(fl_vpn_q), .asid(fl_asid_q),
      .want_super(1'b0), .mode(fl_mode_q), .lk_match(unused_lksw[w]), .fl_match(sw_m[w]));
  end

  // Superpage set is scanned last so it overrides the 4K set; lowest way last wins.
  always_comb begin
    w_lk_hit   = 1'b0;
    w_lk_ppn   = '0;
    w_lk_flags = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (lk4_m[w]) begin
        w_lk_hit   = 1'b1;
        w_lk_ppn   = ppn_q[lk_idx4][w];
        w_lk_flags = flags_q[lk_idx4][w];
      end
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (lks_m[w]) begin
        w_lk_hit   = 1'b1;
        w_lk_ppn   = {ppn_q[lk_idxs][w][PPN_W-1:SV32_SPLIT], w_lk_vpn[SV32_SPLIT-1:0]};
        w_lk_flags = flags_q[lk_idxs][w];
      end
    end
    if (w_flush_busy) begin
      w_lk_hit   = 1'b0;
      w_lk_ppn   = '0;
      w_lk_flags = '0;
    end
  end

  // Victim: in-place overwrite, then lowest free way, then round-robin.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    use_rr = 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (rf_m[w]) begin
        victim = WW'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = WAYS-1; w >= 0; w--) begin
        if (!valid_q[rf_idx][w]) begin
          victim = WW'(w);
          found  = 1'b1;
        end
      end
    end
    if (!found) begin
      victim = rr_q[rf_idx];
      use_rr = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (fl_all) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (state_q == TLB_SWEEP) begin
      valid_q[cnt_q] <= valid_q[cnt_q] & ~sw_m;
    end else if (rf_en) begin
      valid_q[rf_idx][victim] <= 1'b1;
      if (use_rr) rr_q[rf_idx] <= (rr_q[rf_idx] == WW'(WAYS-1)) ? '0 : rr_q[rf_idx] + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rf_en) begin
      super_q[rf_idx][victim] <= w_wsuper;
      vpn_q[rf_idx][victim]   <= w_wvpn;
      asid_q[rf_idx][victim]  <= w_wasid;
      ppn_q[rf_idx][victim]   <= w_wppn;
      flags_q[rf_idx][victim] <= w_wflags;
    end
    if (fl_start) begin
      fl_vpn_q  <= w_flush_vpn;
      fl_asid_q <= w_flush_asid;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= TLB_IDLE;
      cnt_q     <= '0;
      fl_mode_q <= TLBF_ALL;
    end else begin
      state_q <= state_d;
      if (fl_start) begin
        cnt_q     <= '0;
        fl_mode_q <= w_flush_mode;
      end else if (state_q == TLB_SWEEP) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLB_IDLE:  if (w_flush_req) state_d = (w_flush_mode == TLBF_ALL) ? TLB_DONE : TLB_SWEEP;
      TLB_SWEEP: if (cnt_q == SW'(SETS-1)) state_d = TLB_DONE;
      default:   state_d = TLB_IDLE;
    endcase
  end

  always_comb begin
    w_flush_busy = (state_q == TLB_SWEEP);
    w_flush_done = (state_q == TLB_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      w_hit_cnt  <= '0;
      w_miss_cnt <= '0;
    end else if (w_lk_req) begin
      if (w_lk_hit) begin
        if (w_hit_cnt != {CNT_W{1'b1}}) w_hit_cnt <= w_hit_cnt + 1'b1;
      end else begin
        if (w_miss_cnt != {CNT_W{1'b1}}) w_miss_cnt <= w_miss_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/m_tlb_assoc.md
Name: m_tlb_assoc

Overview:
- Parametrised set-associative TLB. Successor to the direct-mapped per-access-type TLB inside the MMU.
- Adds N-way sets, ASID tagging, global entries and 4 MiB superpage entries.
- Adds selective SFENCE.VMA flush via a sweep state machine, plus hit/miss counters.
- Sits between the page walker (refill port) and the CPU address path (combinational lookup port). The MMU instantiates one per access type.

Parameters:
- WAYS, 2, associativity (power of 2, >=1)
- SETS, 16, sets per way (power of 2, >=2)
- VPN_W, 20, virtual page number width (Sv32)
- PPN_W, 22, physical page number width
- ASID_W, 9, address-space ID width
- CNT_W, 32, perf counter width

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- w_lk_req  in  1  lookup valid (counted only when high)
- w_lk_vpn  in  VPN_W  lookup VPN
- w_lk_asid  in  ASID_W  current ASID (satp)
- w_lk_hit  out  1  combinational hit
- w_lk_ppn  out  PPN_W  translated PPN (superpage-merged)
- w_lk_flags  out  8  stored PTE flags {D,A,G,U,X,W,R,V}
- w_we  in  1  refill strobe
- w_wvpn  in  VPN_W  refill VPN
- w_wasid  in  ASID_W  refill ASID
- w_wppn  in  PPN_W  refill PPN
- w_wflags  in  8  refill PTE flags (G taken from bit 5)
- w_wsuper  in  1  refill is a 4 MiB superpage
- w_flush_req  in  1  flush request pulse
- w_flush_mode  in  2  0=all, 1=by ASID, 2=by VPN, 3=by VPN+ASID
- w_flush_vpn  in  VPN_W  flush VPN
- w_flush_asid  in  ASID_W  flush ASID
- w_flush_busy  out  1  sweep in progress
- w_flush_done  out  1  one-cycle completion pulse
- w_hit_cnt  out  CNT_W  saturating hit counter
- w_miss_cnt  out  CNT_W  saturating miss counter

Behaviour:
- Reset: all valid bits 0, round-robin pointers 0, counters 0, w_flush_busy=0, w_flush_done=0, FSM=IDLE. Reset mid-sweep aborts the sweep; no done pulse.
- Indexing:
  - 4 KiB entries use set idx4 = vpn[log2(SETS)-1:0].
  - Superpage entries use idxS = vpn[10+log2(SETS)-1:10].
  - Lookup probes both sets in the same cycle.
- Entry match: valid && (G || asid==lk_asid) && (super ? vpn[19:10]==tag[19:10] : full vpn match). Only entries with super=1 are matched in the idxS set, and only entries with super=0 in the idx4 set.
- w_lk_hit/w_lk_ppn/w_lk_flags are combinational, zero latency.
  - Superpage output: ppn = {entry_ppn[PPN_W-1:10], lk_vpn[9:0]}.
  - Miss: ppn=0, flags=0.
  - Multiple matches (invariant violation): lowest way wins, superpage set before 4K set.
- Lookup while w_flush_busy: w_lk_hit forced 0, counted as a miss.
- Counters: when w_lk_req, increment hit or miss. Saturate at all-ones; no wrap.
- Refill, effective next cycle:
  - Existing matching entry (same vpn/super/asid, or global) is overwritten in place.
  - Else the lowest invalid way is used.
  - Else the set's round-robin victim is used, and that set's pointer advances mod WAYS.
  - Refill during w_flush_busy is dropped.
  - Refill plus flush_req in the same IDLE cycle: flush wins, refill dropped.
- FSM states:
  - IDLE: flush_req with mode 0 clears all valid bits in one cycle; done pulses the next cycle; busy stays 0.
  - IDLE: flush_req with mode 1-3 latches vpn/asid/mode, sets set counter=0, goes to SWEEP, and busy=1 the next cycle.
  - SWEEP: each cycle, invalidate every way in set[counter] that matches the filter.
    - Mode 1: asid match && !G.
    - Mode 2: VPN match (super entries compare vpn[19:10]), G ignored.
    - Mode 3: VPN match && asid match && !G.
    - Counter increments. After set SETS-1, go to DONE.
  - DONE: busy=0, done=1 for one cycle, back to IDLE.
  - Sweep length is exactly SETS cycles. flush_req during SWEEP/DONE is ignored.
- Widths: set counter log2(SETS) bits; wraps only at the DONE transition.

Decomposition:
- Shared package/define header:
  - Flush-mode constants TLBF_ALL/ASID/VPN/VPNASID.
  - PTE flag bit positions (PTE_V..PTE_D), reusing the existing PTE_A_MASK/PTE_D_MASK naming.
  - Sv32 split constant (10).
- One sub-module: m_tlb_way_match, purely combinational. Takes an entry, vpn, asid and flush-filter mode. Outputs lookup-match and flush-match. Instantiated per way for the idx4 set, the idxS set and the sweep set.

Test Plan:
- Refill vpn=0x12345, asid=3, ppn=0x00ABC, flags=0x0F. Then lookup vpn=0x12345 asid=3 -> hit=1, ppn=0x00ABC, flags=0x0F. Lookup with asid=4 -> hit=0, miss_cnt increments.
- Superpage refill vpn=0x40000, ppn=0x3FF000, super=1. Lookup vpn=0x40123 -> hit, ppn=0x3FF123.
- WAYS=2: refill three distinct VPNs into set 0 -> third evicts way0 (RR ptr=0). Lookup of the first VPN misses; the other two hit.
- Global entry (flags bit5=1) asid=1; flush mode1 asid=1 -> busy=1 for exactly SETS=16 cycles, then done pulse. Global entry still hits; non-global asid=1 entries miss.
- Flush mode0 with simultaneous w_we -> all entries miss next cycle, refilled VPN absent, done pulses one cycle later with busy never asserted.
- Assert RST at sweep cycle 5 -> busy=0 next cycle, no done pulse, counters=0, all lookups miss.
